// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared constants for the SD-card SPI-mode init sequencer
// Purpose: FSM state encodings, command indices, command argument/CRC lookup,
//          R1 values and err_code values. No ports.
package sd_pkg;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE     = 4'd0;
  localparam state_t ST_PWRUP    = 4'd1;
  localparam state_t ST_CMD_SEND = 4'd2;
  localparam state_t ST_R1_WAIT  = 4'd3;
  localparam state_t ST_R_TAIL   = 4'd4;
  localparam state_t ST_GAP      = 4'd5;
  localparam state_t ST_DECIDE   = 4'd6;
  localparam state_t ST_DONE     = 4'd7;
  localparam state_t ST_ERROR    = 4'd8;

  localparam logic [5:0] CMD0   = 6'd0;
  localparam logic [5:0] CMD8   = 6'd8;
  localparam logic [5:0] ACMD41 = 6'd41;
  localparam logic [5:0] CMD55  = 6'd55;
  localparam logic [5:0] CMD58  = 6'd58;

  localparam logic [31:0] ARG_CMD8   = 32'h0000_01AA;
  localparam logic [31:0] ARG_ACMD41 = 32'h4000_0000;
  localparam logic [7:0]  CRC_CMD0   = 8'h95;
  localparam logic [7:0]  CRC_CMD8   = 8'h87;
  localparam logic [7:0]  CRC_OTHER  = 8'h01;

  // First frame byte carries start bit 0 and transmission bit 1.
  localparam logic [1:0] FRAME_START = 2'b01;

  localparam logic [7:0] R1_IDLE  = 8'h01;
  localparam logic [7:0] R1_READY = 8'h00;

  localparam logic [2:0] ERR_NONE   = 3'd0;
  localparam logic [2:0] ERR_CMD0   = 3'd1;
  localparam logic [2:0] ERR_CMD8   = 3'd2;
  localparam logic [2:0] ERR_ACMD41 = 3'd3;
  localparam logic [2:0] ERR_CMD58  = 3'd4;
  localparam logic [2:0] ERR_NCR    = 3'd5;

  function automatic logic [31:0] arg_of(input logic [5:0] idx);
    case (idx)
      CMD8:    arg_of = ARG_CMD8;
      ACMD41:  arg_of = ARG_ACMD41;
      default: arg_of = 32'h0;
    endcase
  endfunction

  function automatic logic [7:0] crc_of(input logic [5:0] idx);
    case (idx)
      CMD0:    crc_of = CRC_CMD0;
      CMD8:    crc_of = CRC_CMD8;
      default: crc_of = CRC_OTHER;
    endcase
  endfunction

  // R7 (CMD8) and R3 (CMD58) carry four bytes after R1.
  function automatic logic has_tail(input logic [5:0] idx);
    has_tail = (idx == CMD8) || (idx == CMD58);
  endfunction

endpackage

// File: rtl/sd_cmd_framer.sv
// rtl/sd_cmd_framer.sv - selects the byte of a 6-byte SD command frame
// Purpose: combinational frame byte lookup.
// Ports: cmd_idx (6) command index, cmd_arg (32) argument, cmd_crc (8) CRC byte
//        incl. end bit, byte_idx (4) position 0..5, frame_byte (8) byte to send.
module sd_cmd_framer
  import sd_pkg::*;
(
  input  logic [5:0]  cmd_idx,
  input  logic [31:0] cmd_arg,
  input  logic [7:0]  cmd_crc,
  input  logic [3:0]  byte_idx,
  output logic [7:0]  frame_byte
);

  always_comb begin
    frame_byte = 8'hFF;
    case (byte_idx)
      4'd0:    frame_byte = {FRAME_START, cmd_idx};
      4'd1:    frame_byte = cmd_arg[31:24];
      4'd2:    frame_byte = cmd_arg[23:16];
      4'd3:    frame_byte = cmd_arg[15:8];
      4'd4:    frame_byte = cmd_arg[7:0];
      4'd5:    frame_byte = cmd_crc;
      default: frame_byte = 8'hFF;
    endcase
  end

endmodule

// File: rtl/sd_init_sequencer.sv
// rtl/sd_init_sequencer.sv - SD-card SPI-mode initialisation sequencer
// Purpose: drives a byte-level SPI engine through power-up clocks, CMD0, CMD8,
//          CMD55/ACMD41 polling and CMD58; owns chip select and slow-clock request.
// Ports: clk, reset (async active-low), start (pulse), init_done, init_err,
//        err_code (3), card_sdhc, spi_slow, spi_cs_n, spi_tx_valid, spi_tx_byte (8),
//        spi_tx_ready, spi_rx_valid, spi_rx_byte (8).
module sd_init_sequencer
  import sd_pkg::*;
#(
  parameter int DUMMY_BYTES  = 10,
  parameter int NCR_MAX      = 8,
  parameter int ACMD41_TRIES = 1000,
  parameter int CMD0_TRIES   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       init_done,
  output logic       init_err,
  output logic [2:0] err_code,
  output logic       card_sdhc,
  output logic       spi_slow,
  output logic       spi_cs_n,
  output logic       spi_tx_valid,
  output logic [7:0] spi_tx_byte,
  input  logic       spi_tx_ready,
  input  logic       spi_rx_valid,
  input  logic [7:0] spi_rx_byte
);

  localparam int NCR_W  = $clog2(NCR_MAX + 1);
  localparam int ACMD_W = $clog2(ACMD41_TRIES + 1);
  localparam int C0_W   = $clog2(CMD0_TRIES + 1);

  state_t            state;
  logic [3:0]        cnt;
  logic [NCR_W-1:0]  ncr_cnt;
  logic [ACMD_W-1:0] acmd_cnt;
  logic [C0_W-1:0]   cmd0_cnt;
  logic [5:0]        cur_cmd;
  logic [7:0]        r1;
  logic [31:0]       tail;
  logic              timeout;
  logic              busy;       // a byte was accepted and its rx pulse is pending
  logic [7:0]        frame_byte;

  // Only CCS and the CMD8 echo are interpreted; other tail bits are carried along.
  logic unused_tail_bits;
  assign unused_tail_bits = ^{tail[31], tail[29:12]};

  wire rx_done   = spi_rx_valid && busy;
  wire byte_state = (state == ST_PWRUP) || (state == ST_CMD_SEND) || (state == ST_R1_WAIT) ||
                    (state == ST_R_TAIL) || (state == ST_GAP);

  sd_cmd_framer u_framer (
    .cmd_idx   (cur_cmd),
    .cmd_arg   (arg_of(cur_cmd)),
    .cmd_crc   (crc_of(cur_cmd)),
    .byte_idx  (cnt),
    .frame_byte(frame_byte)
  );

  assign spi_cs_n  = !((state == ST_CMD_SEND) || (state == ST_R1_WAIT) || (state == ST_R_TAIL));
  assign spi_slow  = (state != ST_DONE);
  assign init_done = (state == ST_DONE);
  assign init_err  = (state == ST_ERROR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      ncr_cnt      <= '0;
      acmd_cnt     <= '0;
      cmd0_cnt     <= '0;
      cur_cmd      <= CMD0;
      r1           <= 8'hFF;
      tail         <= '0;
      timeout      <= 1'b0;
      busy         <= 1'b0;
      err_code     <= ERR_NONE;
      card_sdhc    <= 1'b0;
      spi_tx_valid <= 1'b0;
      spi_tx_byte  <= 8'hFF;
    end else begin
      // Byte issue: one byte in flight, next one only after its rx pulse.
      if (spi_tx_valid && spi_tx_ready) begin
        spi_tx_valid <= 1'b0;
        busy         <= 1'b1;
      end else if (rx_done) begin
        busy <= 1'b0;
      end else if (!spi_tx_valid && !busy && byte_state) begin
        spi_tx_valid <= 1'b1;
        spi_tx_byte  <= (state == ST_CMD_SEND) ? frame_byte : 8'hFF;
      end

      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state     <= ST_PWRUP;
            cnt       <= '0;
            cmd0_cnt  <= '0;
            acmd_cnt  <= '0;
            err_code  <= ERR_NONE;
            card_sdhc <= 1'b0;
          end
        end
        ST_PWRUP: begin
          if (rx_done) begin
            if (cnt == 4'(DUMMY_BYTES - 1)) begin
              cnt     <= '0;
              cur_cmd <= CMD0;
              state   <= ST_CMD_SEND;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        ST_CMD_SEND: begin
          if (rx_done) begin
            if (cnt == 4'd5) begin
              cnt     <= '0;
              ncr_cnt <= '0;
              timeout <= 1'b0;
              state   <= ST_R1_WAIT;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        ST_R1_WAIT: begin
          if (rx_done) begin
            if (!spi_rx_byte[7]) begin
              r1    <= spi_rx_byte;
              cnt   <= '0;
              state <= has_tail(cur_cmd) ? ST_R_TAIL : ST_GAP;
            end else if (ncr_cnt == NCR_W'(NCR_MAX - 1)) begin
              // Power-up (CMD0 retry) or ERROR follows, both deselect anyway.
              timeout <= 1'b1;
              state   <= ST_DECIDE;
            end else begin
              ncr_cnt <= ncr_cnt + 1'b1;
            end
          end
        end
        ST_R_TAIL: begin
          if (rx_done) begin
            tail <= {tail[23:0], spi_rx_byte};
            if (cnt == 4'd3) state <= ST_GAP;
            else cnt <= cnt + 4'd1;
          end
        end
        ST_GAP: begin
          if (rx_done) state <= ST_DECIDE;
        end
        ST_DECIDE: begin
          cnt   <= '0;
          state <= ST_CMD_SEND;
          if (cur_cmd == CMD0) begin
            if (!timeout && r1 == R1_IDLE) begin
              cur_cmd <= CMD8;
            end else if (cmd0_cnt == C0_W'(CMD0_TRIES - 1)) begin
              state    <= ST_ERROR;
              err_code <= ERR_CMD0;
            end else begin
              cmd0_cnt <= cmd0_cnt + 1'b1;
              state    <= ST_PWRUP;
            end
          end else if (timeout) begin
            state    <= ST_ERROR;
            err_code <= ERR_NCR;
          end else begin
            case (cur_cmd)
              CMD8: begin
                if (r1 == R1_IDLE && tail[11:0] == 12'h1AA) begin
                  cur_cmd <= CMD55;
                end else begin
                  state    <= ST_ERROR;
                  err_code <= ERR_CMD8;
                end
              end
              CMD55: begin
                if (r1[7:1] == 7'd0) begin
                  acmd_cnt <= acmd_cnt + 1'b1;
                  cur_cmd  <= ACMD41;
                end else begin
                  state    <= ST_ERROR;
                  err_code <= ERR_ACMD41;
                end
              end
              ACMD41: begin
                if (r1 == R1_READY) begin
                  cur_cmd <= CMD58;
                end else if (r1 == R1_IDLE && acmd_cnt != ACMD_W'(ACMD41_TRIES)) begin
                  cur_cmd <= CMD55;
                end else begin
                  state    <= ST_ERROR;
                  err_code <= ERR_ACMD41;
                end
              end
              default: begin
                if (r1 == R1_READY) begin
                  card_sdhc <= tail[30];
                  state     <= ST_DONE;
                end else begin
                  state    <= ST_ERROR;
                  err_code <= ERR_CMD58;
                end
              end
            endcase
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_init_sequencer.sv
// tb/tb_sd_init_sequencer.sv - directed bench: SPI engine model plus SD card responder
module tb_sd_init_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       init_done, init_err, card_sdhc, spi_slow, spi_cs_n;
  logic [2:0] err_code;
  logic       spi_tx_valid, spi_tx_ready, spi_rx_valid;
  logic [7:0] spi_tx_byte, spi_rx_byte;

  always #5 clk = ~clk;

  sd_init_sequencer #(.ACMD41_TRIES(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .init_done   (init_done),
    .init_err    (init_err),
    .err_code    (err_code),
    .card_sdhc   (card_sdhc),
    .spi_slow    (spi_slow),
    .spi_cs_n    (spi_cs_n),
    .spi_tx_valid(spi_tx_valid),
    .spi_tx_byte (spi_tx_byte),
    .spi_tx_ready(spi_tx_ready),
    .spi_rx_valid(spi_rx_valid),
    .spi_rx_byte (spi_rx_byte)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // card behaviour: 0 SDHC happy, 1 bad CMD8 echo, 2 never leaves idle, 3 CMD0 silent
  int mode = 0;
  int n_pre, n_tot, n_cs0, n_cmd0, n_cmd8, n_cmd55, n_acmd, n_cmd58, bad_dummy;
  int hs_viol = 0;
  int post_err_tx = 0;
  bit seen_cs0;
  bit hit_cmd8_b3;
  logic [7:0] cmd0_frame [0:5];
  logic [7:0] fr [0:5];
  int fcnt;
  logic [7:0] rq [$];

  logic       eng_busy;
  logic [1:0] eng_cnt;
  logic [7:0] eng_rx, miso_b;

  assign spi_tx_ready = !eng_busy;

  task automatic reset_counters();
    n_pre = 0; n_tot = 0; n_cs0 = 0; n_cmd0 = 0; n_cmd8 = 0; n_cmd55 = 0;
    n_acmd = 0; n_cmd58 = 0; bad_dummy = 0; seen_cs0 = 0; hit_cmd8_b3 = 0;
  endtask

  task automatic push4(input logic [31:0] w);
    rq.push_back(w[31:24]); rq.push_back(w[23:16]);
    rq.push_back(w[15:8]);  rq.push_back(w[7:0]);
  endtask

  task automatic respond();
    logic [5:0] idx;
    idx = fr[0][5:0];
    case (idx)
      6'd0: begin
        if (n_cmd0 == 0) for (int i = 0; i < 6; i++) cmd0_frame[i] = fr[i];
        n_cmd0++;
        if (mode != 3) begin rq.push_back(8'hFF); rq.push_back(8'h01); end
      end
      6'd8: begin
        n_cmd8++;
        rq.push_back(8'hFF); rq.push_back(8'h01);
        push4((mode == 1) ? 32'h0000_01AB : 32'h0000_01AA);
      end
      6'd55: begin
        n_cmd55++;
        rq.push_back(8'hFF); rq.push_back(8'h01);
      end
      6'd41: begin
        n_acmd++;
        rq.push_back(8'hFF);
        rq.push_back((mode == 2 || n_acmd < 3) ? 8'h01 : 8'h00);
      end
      6'd58: begin
        n_cmd58++;
        rq.push_back(8'hFF); rq.push_back(8'h00);
        push4(32'hC0FF_8000);
      end
      default: rq.push_back(8'h04);
    endcase
  endtask

  task automatic card_xchg(input logic [7:0] mosi, input logic cs_n, output logic [7:0] miso);
    n_tot++;
    if (cs_n) begin
      miso = 8'hFF;
      fcnt = 0;
      rq.delete();
      if (mosi != 8'hFF) bad_dummy++;
      if (!seen_cs0) n_pre++;
    end else begin
      seen_cs0 = 1;
      n_cs0++;
      miso = (rq.size() > 0) ? rq.pop_front() : 8'hFF;
      if (fcnt == 0 && mosi[7:6] == 2'b01) begin
        fr[0] = mosi;
        fcnt = 1;
      end else if (fcnt > 0) begin
        fr[fcnt] = mosi;
        fcnt++;
        if (fcnt == 3 && fr[0] == 8'h48) hit_cmd8_b3 = 1;
        if (fcnt == 6) begin
          fcnt = 0;
          respond();
        end
      end
    end
  endtask

  // SPI engine: accepts a byte, reports the exchanged byte two cycles later.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      eng_busy     <= 1'b0;
      eng_cnt      <= 2'd0;
      spi_rx_valid <= 1'b0;
      spi_rx_byte  <= 8'hFF;
      rq.delete();
      fcnt = 0;
    end else begin
      spi_rx_valid <= 1'b0;
      if (spi_tx_valid && eng_busy) hs_viol++;
      if (eng_busy) begin
        if (eng_cnt == 2'd1) begin
          eng_busy     <= 1'b0;
          spi_rx_valid <= 1'b1;
          spi_rx_byte  <= eng_rx;
        end else begin
          eng_cnt <= eng_cnt + 2'd1;
        end
      end else if (spi_tx_valid) begin
        card_xchg(spi_tx_byte, spi_cs_n, miso_b);
        eng_rx   <= miso_b;
        eng_busy <= 1'b1;
        eng_cnt  <= 2'd0;
      end
    end
  end

  always @(posedge clk) if (init_err && spi_tx_valid) post_err_tx++;

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int budget);
    bit ended;
    ended = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (init_done || init_err) begin ended = 1; break; end
    end
    #1;
    chk({tag, "_finished"}, {31'd0, ended}, 32'd1);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_done"}, {31'd0, init_done}, 32'd0);
    chk({tag, "_err"}, {31'd0, init_err}, 32'd0);
    chk({tag, "_code"}, {29'd0, err_code}, 32'd0);
    chk({tag, "_sdhc"}, {31'd0, card_sdhc}, 32'd0);
    chk({tag, "_slow"}, {31'd0, spi_slow}, 32'd1);
    chk({tag, "_cs_n"}, {31'd0, spi_cs_n}, 32'd1);
    chk({tag, "_txv"}, {31'd0, spi_tx_valid}, 32'd0);
    chk({tag, "_txb"}, {24'd0, spi_tx_byte}, 32'hFF);
  endtask

  logic [7:0] exp_cmd0 [0:5];
  int prev_err_tx;

  initial begin
    exp_cmd0[0] = 8'h40; exp_cmd0[1] = 8'h00; exp_cmd0[2] = 8'h00;
    exp_cmd0[3] = 8'h00; exp_cmd0[4] = 8'h00; exp_cmd0[5] = 8'h95;
    reset_counters();
    #3 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_idle_outputs("rst");
    @(negedge clk) reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk_idle_outputs("idle");

    // happy path, SDHC card
    mode = 0; reset_counters();
    pulse_start();
    wait_end("happy", 20000);
    chk("happy_done", {31'd0, init_done}, 32'd1);
    chk("happy_sdhc", {31'd0, card_sdhc}, 32'd1);
    chk("happy_slow", {31'd0, spi_slow}, 32'd0);
    chk("happy_cs_n", {31'd0, spi_cs_n}, 32'd1);
    chk("happy_pre_bytes", n_pre, 10);
    chk("happy_dummy_ff", bad_dummy, 0);
    for (int i = 0; i < 6; i++) chk($sformatf("cmd0_byte%0d", i), {24'd0, cmd0_frame[i]}, {24'd0, exp_cmd0[i]});
    chk("happy_acmd41", n_acmd, 3);
    chk("happy_cmd58", n_cmd58, 1);

    // bad CMD8 echo
    mode = 1; reset_counters();
    pulse_start();
    #1 chk("restart_clears_done", {31'd0, init_done}, 32'd0);
    wait_end("cmd8", 20000);
    chk("cmd8_err", {31'd0, init_err}, 32'd1);
    chk("cmd8_code", {29'd0, err_code}, 32'd2);
    chk("cmd8_cs_n", {31'd0, spi_cs_n}, 32'd1);
    prev_err_tx = post_err_tx;
    repeat (40) @(posedge clk);
    #1 chk("cmd8_no_tx", post_err_tx - prev_err_tx, 0);
    chk("cmd8_pre_bytes", n_pre, 10);

    // card never leaves idle
    mode = 2; reset_counters();
    pulse_start();
    wait_end("acmd", 20000);
    chk("acmd_err", {31'd0, init_err}, 32'd1);
    chk("acmd_code", {29'd0, err_code}, 32'd3);
    chk("acmd_frames", n_acmd, 5);
    chk("acmd_cmd55", n_cmd55, 5);

    // CMD0 never answered
    mode = 3; reset_counters();
    pulse_start();
    wait_end("cmd0", 20000);
    chk("cmd0_err", {31'd0, init_err}, 32'd1);
    chk("cmd0_code", {29'd0, err_code}, 32'd1);
    chk("cmd0_attempts", n_cmd0, 3);
    chk("cmd0_total_bytes", n_tot, 72);
    chk("cmd0_cs0_bytes", n_cs0, 42);
    mode = 0; reset_counters();
    pulse_start();
    wait_end("retry", 20000);
    chk("retry_done", {31'd0, init_done}, 32'd1);
    chk("retry_code", {29'd0, err_code}, 32'd0);

    // reset in the middle of CMD8
    mode = 0; reset_counters();
    pulse_start();
    begin
      bit hit;
      hit = 0;
      for (int i = 0; i < 5000; i++) begin
        @(posedge clk);
        if (hit_cmd8_b3) begin hit = 1; break; end
      end
      chk("cmd8_b3_reached", {31'd0, hit}, 32'd1);
    end
    #1 reset = 1'b0;
    #1 chk_idle_outputs("midrst");
    @(negedge clk) reset = 1'b1;
    reset_counters();
    pulse_start();
    wait_end("after_rst", 20000);
    chk("after_rst_done", {31'd0, init_done}, 32'd1);
    chk("after_rst_sdhc", {31'd0, card_sdhc}, 32'd1);
    chk("after_rst_pre", n_pre, 10);
    chk("handshake_viol", hs_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
